// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port unified instruction/data memory between the fetch
//   stage and the load/store path. At most one transaction is outstanding.
//   Data accesses win over fetch. A streak counter forces a fetch grant once
//   STARVE consecutive data grants have been made while fetch was waiting.
//
// Parameters
//   AW      address width
//   DW      data width
//   LAT     memory read latency, issue edge to valid mem_rdata (1..7)
//   STARVE  max consecutive data grants while fetch waits (1..15)
//
// Ports
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_if_req / i_if_addr       fetch request (held until ack) and address
//   o_if_ack / o_if_rdata      fetch completion pulse and read data
//   o_if_stall                 fetch pending and not acknowledged this cycle
//   i_d_req / i_d_we / i_d_be  data request, store flag, byte enables
//   i_d_addr / i_d_wdata       data address and store data
//   o_d_ack / o_d_rdata        data completion pulse and load data
//   o_d_stall                  data pending and not acknowledged this cycle
//   o_mem_*                    memory issue port (en, we, be, addr, wdata)
//   i_mem_rdata                memory read data, valid LAT cycles after issue
//   o_busy                     a transaction is outstanding
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no outstanding access; arbitrate and issue combinationally
// WAIT  | access issued; count down latency, ack when counter hits 0
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int LAT    = 2,
  parameter int STARVE = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,

  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_ack,
  output logic [DW-1:0] o_if_rdata,
  output logic          o_if_stall,

  input  logic          i_d_req,
  input  logic          i_d_we,
  input  logic [3:0]    i_d_be,
  input  logic [AW-1:0] i_d_addr,
  input  logic [DW-1:0] i_d_wdata,
  output logic          o_d_ack,
  output logic [DW-1:0] o_d_rdata,
  output logic          o_d_stall,

  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [3:0]    o_mem_be,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,

  output logic          o_busy
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_WAIT = 1'b1;

  localparam logic [2:0] CNT_LOAD   = 3'(LAT - 1);
  localparam logic [3:0] STREAK_MAX = 4'(STARVE);

  logic       r_state;
  logic       r_owner_d;   // 1 = data path owns the outstanding access
  logic       r_store;     // outstanding access is a store
  logic [2:0] r_cnt;
  logic [3:0] r_streak;

  logic w_issue;
  logic w_grant_d;
  logic w_ack;

  // Data wins unless fetch has been passed over STARVE times in a row.
  assign w_grant_d = i_d_req & ~(i_if_req & (r_streak == STREAK_MAX));
  assign w_issue   = (r_state == ST_IDLE) & ~i_rst & (i_if_req | i_d_req);
  // Reset discards the outstanding access, so no ack may escape during it.
  assign w_ack     = (r_state == ST_WAIT) & (r_cnt == 3'd0) & ~i_rst;

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_be    = 4'h0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_issue) begin
      o_mem_en = 1'b1;
      if (w_grant_d) begin
        o_mem_we    = i_d_we;
        o_mem_be    = i_d_be;
        o_mem_addr  = i_d_addr;
        o_mem_wdata = i_d_wdata;
      end else begin
        o_mem_be   = 4'hF;
        o_mem_addr = i_if_addr;
      end
    end
  end

  always_comb begin
    o_if_ack   = w_ack & ~r_owner_d;
    o_d_ack    = w_ack & r_owner_d;
    o_if_rdata = o_if_ack ? i_mem_rdata : '0;
    // Stores never sample the memory read bus.
    o_d_rdata  = (o_d_ack & ~r_store) ? i_mem_rdata : '0;
    o_if_stall = i_if_req & ~o_if_ack;
    o_d_stall  = i_d_req & ~o_d_ack;
    o_busy     = (r_state != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_owner_d <= 1'b0;
      r_store   <= 1'b0;
      r_cnt     <= 3'd0;
      r_streak  <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_state   <= ST_WAIT;
            r_owner_d <= w_grant_d;
            r_store   <= w_grant_d & i_d_we;
            r_cnt     <= (w_grant_d & i_d_we) ? 3'd0 : CNT_LOAD;
            // Streak only grows while fetch is actually waiting; it cannot
            // pass STREAK_MAX because that value forces a fetch grant.
            if (!w_grant_d)     r_streak <= 4'd0;
            else if (i_if_req)  r_streak <= r_streak + 4'd1;
            else                r_streak <= 4'd0;
          end
        end
        ST_WAIT: begin
          if (r_cnt != 3'd0) r_cnt   <= r_cnt - 3'd1;
          else               r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int LAT    = 2;
  localparam int STARVE = 4;
  localparam int NCYC   = 3000;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          if_stall;
  logic          d_req;
  logic          d_we;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          d_stall;
  logic          mem_en;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT), .STARVE(STARVE)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_if_req   (if_req),
    .i_if_addr  (if_addr),
    .o_if_ack   (if_ack),
    .o_if_rdata (if_rdata),
    .o_if_stall (if_stall),
    .i_d_req    (d_req),
    .i_d_we     (d_we),
    .i_d_be     (d_be),
    .i_d_addr   (d_addr),
    .i_d_wdata  (d_wdata),
    .o_d_ack    (d_ack),
    .o_d_rdata  (d_rdata),
    .o_d_stall  (d_stall),
    .o_mem_en   (mem_en),
    .o_mem_we   (mem_we),
    .o_mem_be   (mem_be),
    .o_mem_addr (mem_addr),
    .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata),
    .o_busy     (busy)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Transaction-level reference: one outstanding access with an absolute
  // completion cycle, plus the spec's streak rule as a plain integer.
  bit            m_busy   = 0;
  bit            m_data   = 0;
  bit            m_store  = 0;
  int            m_ack    = 0;
  int            m_streak = 0;
  logic [DW-1:0] m_rd     = '0;
  bit            if_done  = 0;
  bit            d_done   = 0;
  int            n_forced = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_and_step();
    bit exp_ack, issue, gd, ack_f, ack_d;
    logic [DW-1:0] exp_ifr, exp_dr;
    exp_ack = m_busy && (cyc == m_ack) && !rst;
    issue   = !m_busy && !rst && (if_req || d_req);
    gd      = d_req && !(if_req && (m_streak == STARVE));
    ack_f   = exp_ack && !m_data;
    ack_d   = exp_ack && m_data;
    exp_ifr = ack_f ? m_rd : '0;
    exp_dr  = (ack_d && !m_store) ? m_rd : '0;

    chk("mem_en", mem_en, issue);
    chk("mem_we", mem_we, issue && gd && d_we);
    if (issue) begin
      chk("mem_addr", mem_addr, gd ? d_addr : if_addr);
      chk("mem_be", mem_be, gd ? d_be : 4'hF);
      if (gd && d_we) chk("mem_wdata", mem_wdata, d_wdata);
    end else if (!m_busy && !rst) begin
      chk("idle_addr", mem_addr, 0);
      chk("idle_be", mem_be, 0);
      chk("idle_wdata", mem_wdata, 0);
    end
    chk("if_ack", if_ack, ack_f);
    chk("d_ack", d_ack, ack_d);
    chk("if_rdata", if_rdata, exp_ifr);
    chk("d_rdata", d_rdata, exp_dr);
    chk("if_stall", if_stall, if_req && !ack_f);
    chk("d_stall", d_stall, d_req && !ack_d);
    chk("busy", busy, m_busy);

    if_done = ack_f;
    d_done  = ack_d;

    if (rst) begin
      m_busy   = 0;
      m_streak = 0;
    end else if (issue) begin
      m_busy  = 1;
      m_data  = gd;
      m_store = gd && d_we;
      m_ack   = cyc + (m_store ? 1 : LAT);
      m_rd    = $urandom;
      if (!gd) begin
        if (d_req) n_forced++;
        m_streak = 0;
      end else if (if_req) m_streak = m_streak + 1;
      else                 m_streak = 0;
    end else if (exp_ack) begin
      m_busy = 0;
    end
  endtask

  task automatic drive();
    rst = (cyc < 3) || ($urandom_range(0, 99) == 0);
    if (if_done || !if_req) begin
      if_req  = ($urandom_range(0, 99) < 75);
      if_addr = {$urandom} & 32'hFFFF_FFFC;
    end
    if (d_done || !d_req) begin
      d_req   = ($urandom_range(0, 99) < 85);
      d_we    = $urandom_range(0, 1);
      d_be    = 4'($urandom_range(0, 15));
      d_addr  = $urandom;
      d_wdata = $urandom;
    end
    if (m_busy && (m_ack == cyc) && !m_store) mem_rdata = m_rd;
    else                                      mem_rdata = $urandom;
  endtask

  initial begin
    rst       = 1'b1;
    if_req    = 1'b1;
    if_addr   = 32'h0000_0100;
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_be      = 4'hF;
    d_addr    = 32'h0000_2000;
    d_wdata   = 32'h1234_5678;
    mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);
      check_and_step();
      @(posedge clk);
      #1;
      cyc++;
      drive();
    end
    $display("forced fetch grants: %0d", n_forced);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
